mul_seq: RTL
============

Name: mul_seq

Overview:
- Multicycle multiply sequencer for the ARM multicycle core. Iterative shift-add engine that executes MUL, MLA, UMULL and SMULL over several cycles.
- The main controller FSM issues work through a start/done handshake and can cancel it with flush.
- Each cycle retires BITS_PER_CYCLE multiplier bits. The block produces a 64-bit result plus N/Z flags for the flag-update path.

Parameters:
- WIDTH, 32, operand width in bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4; the value must divide WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a clk edge resets the block.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- op  in  2  operation select: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL; sampled with start.
- a  in  WIDTH  multiplicand (Rm); sampled with start.
- b  in  WIDTH  multiplier (Rs); sampled with start.
- acc  in  WIDTH  accumulate addend (Rn); MLA only; sampled with start.
- flush  in  1  cancel the in-flight operation.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  2*WIDTH  product; holds its value until the next done.
- flag_n  out  1  negative flag of the last completed op.
- flag_z  out  1  zero flag of the last completed op.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, flag_n=0, flag_z=0; all internal registers cleared. Reset has priority over flush, and flush has priority over start.
- States: IDLE, RUN, DONE. N = WIDTH/BITS_PER_CYCLE.
- IDLE, start=1: latch op, a, b and acc; load the step counter with N; clear the partial product; go to RUN.
- IDLE, start=0: stay in IDLE.
- SMULL latch: store |a| and |b| as WIDTH-bit unsigned values (|0x80000000| = 0x80000000), plus neg = a[W-1]^b[W-1].
- RUN, each cycle: add (multiplicand << shift) for each set bit among the low BITS_PER_CYCLE multiplier bits; shift the multiplicand left and the multiplier right by BITS_PER_CYCLE; decrement the counter.
- RUN, last step (counter==1): on that edge, write the finalized product into result, update the flags and go to DONE.
- Finalization rules:
  - MUL: result = {0, P[W-1:0]}.
  - MLA: result = {0, (P[W-1:0]+acc) mod 2^W}.
  - UMULL: result = P.
  - SMULL: result = neg ? (~P+1) : P.
- Flags:
  - MUL/MLA: flag_n = result[W-1]; flag_z = (result[W-1:0]==0).
  - UMULL/SMULL: flag_n = result[2W-1]; flag_z = (result==0).
- DONE: done=1 for exactly this cycle. The next state is IDLE, or RUN if start=1 in DONE (back-to-back issue, same latch rules as IDLE).
- Latency: start sampled in cycle 0 → busy=1 in cycles 1..N → done=1 in cycle N+1. For the defaults, done is in cycle 33.
- busy is registered and equals (state==RUN).
- start while in RUN: ignored, not queued.
- Operand changes after the start edge have no effect.
- flush=1 in RUN: the next state is IDLE; no done; result and flags are unchanged.
- flush=1 in IDLE or DONE: forces IDLE and suppresses any start in the same cycle. A done already high in DONE still completes; result is already written.
- reset==0 mid-RUN: full reset at that edge; no done is produced.
- No overflow indication; the MLA sum and MUL truncation wrap modulo 2^W.

Decomposition:
- Package mul_pkg holds:
  - op_t enum (MUL, MLA, UMULL, SMULL), 2 bits;
  - state_t enum (IDLE, RUN, DONE);
  - OP_ encoding constants;
  - a legality check of BITS_PER_CYCLE against WIDTH.
- Sub-module mul_step (combinational): one BITS_PER_CYCLE-bit shift-add step with inputs {partial, multiplicand, multiplier} and next-value outputs. mul_seq holds the FSM, counter, operand registers and finalization.

Test Plan:
- MUL a=7, b=6, start in cycle 0 → busy in cycles 1-32; done in cycle 33 only; result=0x0000_0000_0000_002A; N=0, Z=0.
- MLA a=0xFFFF_FFFF, b=2, acc=3 → result=0x0000_0000_0000_0001 (wrap); N=0, Z=0.
- UMULL a=0xFFFF_FFFF, b=0xFFFF_FFFF → result=0xFFFF_FFFE_0000_0001; N=1.
- SMULL a=-3, b=5 → result=0xFFFF_FFFF_FFFF_FFF1, N=1. Then SMULL 0x8000_0000×0x8000_0000 → 0x4000_0000_0000_0000, N=0.
- MUL 0×5 completes → Z=1. Then start, with flush=1 in cycle 10 → no done; busy=0 in cycle 11; result stays 0 with Z=1. Re-start in cycle 12 with a=2, b=3 → done in cycle 45, result=6.
- Back-to-back: start asserted in the DONE cycle → new busy the next cycle. start pulsed during RUN → ignored, exactly one done. reset=0 in cycle 5 of RUN → all outputs 0 the following cycle, no done ever.
- Repeat the MUL and SMULL cases with BITS_PER_CYCLE=4 → done in cycle 9 and identical results.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and parameter checks for the multicycle multiply sequencer.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Only 1, 2 or 4 bits per step, and the step count must come out whole.
    function automatic bit bpc_legal(input int width, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (width > 0) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: retires BITS_PER_CYCLE multiplier bits into the partial product.
module mul_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0] i_partial,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_partial,
    output logic [2*WIDTH-1:0] o_mcand,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [2*WIDTH-1:0] w_sum [BITS_PER_CYCLE+1];

    assign w_sum[0] = i_partial;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_bit
        assign w_sum[k+1] = w_sum[k] + (i_mplier[k] ? (i_mcand << k) : '0);
    end

    assign o_partial = w_sum[BITS_PER_CYCLE];
    assign o_mcand   = i_mcand << BITS_PER_CYCLE;
    assign o_mplier  = i_mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/mul_seq.sv
// Iterative MUL/MLA/UMULL/SMULL sequencer: IDLE -> RUN (N steps) -> DONE.
// Handshake: start is taken only in IDLE/DONE; done pulses one cycle with result/flags valid; flush cancels.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   acc,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_n,
    output logic               flag_z,
    output state_t             o_dbg_state
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
        $error("mul_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_finish;

    op_t                r_op;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_partial;
    logic [WIDTH-1:0]   r_acc;
    logic               r_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_flag_n;
    logic               r_flag_z;

    op_t                w_op;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;
    logic [2*WIDTH-1:0] w_p_next;
    logic [2*WIDTH-1:0] w_mc_next;
    logic [WIDTH-1:0]   w_mp_next;
    logic [2*WIDTH-1:0] w_final;
    logic               w_fin_n;
    logic               w_fin_z;

    assign w_op = op_t'(op);

    // SMULL runs on magnitudes; the most negative value maps onto itself as unsigned.
    assign w_load_a = ((w_op == OP_SMULL) && a[WIDTH-1]) ? -a : a;
    assign w_load_b = ((w_op == OP_SMULL) && b[WIDTH-1]) ? -b : b;

    mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_partial (r_partial),
        .i_mcand   (r_mcand),
        .i_mplier  (r_mplier),
        .o_partial (w_p_next),
        .o_mcand   (w_mc_next),
        .o_mplier  (w_mp_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Finalization works on the last step's sum so result lands on the same edge.
    always_comb begin
        w_final = w_p_next;
        w_fin_n = 1'b0;
        w_fin_z = 1'b0;
        case (r_op)
            OP_MUL:   w_final = {{WIDTH{1'b0}}, w_p_next[WIDTH-1:0]};
            OP_MLA:   w_final = {{WIDTH{1'b0}}, (w_p_next[WIDTH-1:0] + r_acc)};
            OP_UMULL: w_final = w_p_next;
            default:  w_final = r_neg ? -w_p_next : w_p_next;
        endcase
        if ((r_op == OP_UMULL) || (r_op == OP_SMULL)) begin
            w_fin_n = w_final[2*WIDTH-1];
            w_fin_z = (w_final == '0);
        end else begin
            w_fin_n = w_final[WIDTH-1];
            w_fin_z = (w_final[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op      <= OP_MUL;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_flag_n  <= 1'b0;
            r_flag_z  <= 1'b0;
        end else begin
            if (w_load) begin
                r_op      <= w_op;
                r_mcand   <= {{WIDTH{1'b0}}, w_load_a};
                r_mplier  <= w_load_b;
                r_acc     <= acc;
                r_neg     <= a[WIDTH-1] ^ b[WIDTH-1];
                r_partial <= '0;
                r_cnt     <= CNT_N;
            end else if (r_state == ST_RUN) begin
                r_partial <= w_p_next;
                r_mcand   <= w_mc_next;
                r_mplier  <= w_mp_next;
                r_cnt     <= r_cnt - CNT_ONE;
            end
            if (w_finish) begin
                r_result <= w_final;
                r_flag_n <= w_fin_n;
                r_flag_z <= w_fin_z;
            end
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign result      = r_result;
    assign flag_n      = r_flag_n;
    assign flag_z      = r_flag_z;
    assign o_dbg_state = r_state;

endmodule
